// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
// Provides the controller state enum, default width and counter sizing.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1 (at least one bit).
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// fa_bit: combinational one-bit full adder cell.
// Ports: a, b, cin -> s (sum bit), cout (carry out).
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per clock.
// Ports: clk, rst_n, start, A, B, Cin -> busy, done, Sum, Cout.
// Option SERIAL_ADDER_SUB_EN adds input Sub (Sum = A - B when Sub=1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = cnt_w(WIDTH);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cell_s;
    logic             cell_c;
    logic             last;

    fa_bit u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; after WIDTH steps acc holds
    // the result LSB-aligned.
    assign acc_nxt = {cell_s, {(WIDTH-1){1'b0}}} | (acc >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa <= A;
                        cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        // A - B as A + ~B + 1.
                        opb   <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
`else
                        opb   <= B;
                        carry <= Cin;
`endif
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    acc   <= acc_nxt;
                    carry <= cell_c;
                    cnt   <= cnt + CW'(1);
                    // Results publish only on entry to DONE, so the
                    // outputs never expose a partial sum.
                    if (last) begin
                        Sum  <= acc_nxt;
                        Cout <= cell_c;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: self-checking bench for serial_adder_ctrl.
// Directed, randomized and back-to-back runs against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width arithmetic result {Cout, Sum}.
    function automatic logic [W:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic ci,
                                         input logic sb);
        logic [W:0] r;
        if (sb)
            r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else
            r = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        return r;
    endfunction

    // Issues one operation, scrambles inputs while it runs, and
    // returns the cycle of the done pulse (0 on timeout).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb,
                         output int lat, output logic [W-1:0] s,
                         output logic co);
        @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            A = W'($urandom); B = W'($urandom);
            Cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
        end
        s = Sum;
        co = Cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, Cout, Sum} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b Sum=%h Cout=%b want all 0",
                     busy, done, Sum, Cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_timing();
        logic [W-1:0] prev;
        int ndone;
        ndone = 0;
        prev = Sum;
        @(negedge clk);
        A = 8'h5A; B = 8'h3C; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            checks++;
            if (busy !== (cyc <= W + 1) || done !== (cyc == W + 1)) begin
                errors++;
                $display("FAIL timing cyc%0d: busy=%b done=%b want %b %b",
                         cyc, busy, done, cyc <= W + 1, cyc == W + 1);
            end
            if (cyc < W + 1) begin
                checks++;
                if (Sum !== prev) begin
                    errors++;
                    $display("FAIL partial cyc%0d: Sum=%h want %h", cyc, Sum, prev);
                end
            end
            if (done) begin
                ndone++;
                checks++;
                if (Sum !== 8'h96 || Cout !== 1'b0) begin
                    errors++;
                    $display("FAIL timing_result: Sum=%h Cout=%b want 96 0",
                             Sum, Cout);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL timing_pulses: got %0d want 1", ndone);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        logic [W-1:0] tb [5] = '{8'h3C, 8'h01, 8'h00, 8'h00, 8'hFF};
        logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W:0]   te [5] = '{9'h096, 9'h100, 9'h100, 9'h000, 9'h1FF};
        int lat;
        logic [W-1:0] s;
        logic co;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tc[i], 1'b0, lat, s, co);
            checks++;
            if (lat != W + 1 || {co, s} !== te[i]) begin
                errors++;
                $display("FAIL directed%0d: lat=%0d res=%h want lat=%0d res=%h",
                         i, lat, {co, s}, W + 1, te[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int at;
        logic [W-1:0] s;
        ndone = 0;
        at = 0;
        s = '0;
        @(negedge clk);
        A = 8'h5A; B = 8'h3C; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 3) begin
                A = 8'h01; B = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                at = cyc;
                s = Sum;
            end
            @(negedge clk);
        end
        checks++;
        if (ndone != 1 || at != W + 1 || s !== 8'h96) begin
            errors++;
            $display("FAIL ignore_start: pulses=%0d at=%0d Sum=%h want 1 %0d 96",
                     ndone, at, s, W + 1);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        int lat;
        logic [W-1:0] s;
        logic co;
        ndone = 0;
        @(negedge clk);
        A = 8'hF0; B = 8'h0F; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Cout, Sum} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b Sum=%h Cout=%b want all 0",
                     busy, done, Sum, Cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_abort: pulses=%0d want 0", ndone);
        end
        do_op(8'h12, 8'h34, 1'b0, 1'b0, lat, s, co);
        checks++;
        if (lat != W + 1 || s !== 8'h46 || co !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d Sum=%h Cout=%b want %0d 46 0",
                     lat, s, co, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] e;
        logic [W-1:0] prev;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic ci;
        int n;
        int last;
        n = 0;
        last = 0;
        prev = Sum;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        A = a; B = b; Cin = ci; sub = 1'b0; start = 1'b1;
        q.push_back(model(a, b, ci, 1'b0));
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (done) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({Cout, Sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: res=%h want %h", n, {Cout, Sum}, e);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last != W + 2) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d want %0d",
                                 cyc - last, W + 2);
                    end
                end
                n++;
                last = cyc;
                if (n < 4) begin
                    a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
                    A = a; B = b; Cin = ci;
                    q.push_back(model(a, b, ci, 1'b0));
                end else begin
                    start = 1'b0;
                end
            end else begin
                checks++;
                if (Sum !== prev) begin
                    errors++;
                    $display("FAIL b2b_hold cyc%0d: Sum=%h want %h", cyc, Sum, prev);
                end
            end
            prev = Sum;
        end
        start = 1'b0;
        checks++;
        if (n != 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d busy=%b want 4 0", n, busy);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic ci;
        logic sb;
        logic [W:0] e;
        int lat;
        logic [W-1:0] s;
        logic co;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            e = model(a, b, ci, sb);
            do_op(a, b, ci, sb, lat, s, co);
            checks++;
            if (lat != W + 1 || {co, s} !== e) begin
                errors++;
                $display("FAIL random%0d: a=%h b=%h ci=%b sb=%b lat=%0d res=%h want %h",
                         i, a, b, ci, sb, lat, {co, s}, e);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        logic [W-1:0] s;
        logic co;
        do_op(8'h10, 8'h01, 1'b0, 1'b1, lat, s, co);
        checks++;
        if (s !== 8'h0F || co !== 1'b1) begin
            errors++;
            $display("FAIL sub_10_01: Sum=%h Cout=%b want 0f 1", s, co);
        end
        do_op(8'h01, 8'h02, 1'b1, 1'b1, lat, s, co);
        checks++;
        if (s !== 8'hFF || co !== 1'b0) begin
            errors++;
            $display("FAIL sub_01_02: Sum=%h Cout=%b want ff 0", s, co);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_timing();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
